serial_subtractor: RTL and testbench

//  Bit-serial two's-complement subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.

---
 rtl/serial_subtractor.sv | 119 +++++++++++
 tb/tb_serial_subtractor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: {borrow_out, diff} = a - b - borrow_in,
// processed one bit per clock LSB first through a single full-subtractor slice.
// Controlled by a start/busy/done handshake; diff and borrow_out are held
// from the done pulse until the next accepted start.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   logic [WIDTH-1:0] r_diff;
   logic [WIDTH-1:0] w_a_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic             r_brw;
   logic             r_busy;
   logic             r_done;
   logic             r_bo;
   logic             w_d;
   logic             w_brw_nxt;
   logic             w_accept;
   logic             w_last;

   // Full-subtractor slice on the current LSBs and the running borrow
   assign w_d       = r_a_sr[0] ^ r_b_sr[0] ^ r_brw;
   assign w_brw_nxt = (~r_a_sr[0] & r_b_sr[0]) | (~(r_a_sr[0] ^ r_b_sr[0]) & r_brw);

   // The minuend register doubles as the result register: each consumed
   // minuend bit frees the MSB slot for the freshly computed difference bit.
   generate
      if (WIDTH == 1) begin : g_w1
         assign w_a_nxt = w_d;
      end else begin : g_wn
         assign w_a_nxt = {w_d, r_a_sr[WIDTH-1:1]};
      end
   endgenerate

   assign w_accept = start && (r_state != S_SHIFT);
   assign w_last   = (r_state == S_SHIFT) && (r_cnt == CNT_LAST);

   // Next-state logic: start is honoured from IDLE and DONE only
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_SHIFT;
         S_SHIFT: if (w_last) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = start ? S_SHIFT : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Operand load, bit-serial shifting and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_sr <= '0;
         r_b_sr <= '0;
         r_brw  <= 1'b0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_diff <= '0;
         r_bo   <= 1'b0;
      end else begin
         r_busy <= (w_state_nxt == S_SHIFT);
         r_done <= (w_state_nxt == S_DONE);
         if (w_accept) begin
            r_a_sr <= a;
            r_b_sr <= b;
            r_brw  <= borrow_in;
            r_cnt  <= '0;
         end else if (r_state == S_SHIFT) begin
            r_a_sr <= w_a_nxt;
            r_b_sr <= r_b_sr >> 1;
            r_brw  <= w_brw_nxt;
            r_cnt  <= r_cnt + 1'b1;
            if (w_last) begin
               r_diff <= w_a_nxt;
               r_bo   <= w_brw_nxt;
            end
         end
      end
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign diff       = r_diff;
   assign borrow_out = r_bo;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH = 8, 4 and 1.
module tb_serial_subtractor;

   logic       clk;
   logic       rst_n;

   logic       st8, bi8, busy8, done8, bo8;
   logic [7:0] a8, b8, diff8;
   logic       st4, bi4, busy4, done4, bo4;
   logic [3:0] a4, b4, diff4;
   logic       st1, bi1, busy1, done1, bo1;
   logic [0:0] a1, b1, diff1;

   int n_checks;
   int n_errors;

   serial_subtractor #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8), .borrow_in(bi8),
      .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
   );

   serial_subtractor #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(st4), .a(a4), .b(b4), .borrow_in(bi4),
      .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4)
   );

   serial_subtractor #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(st1), .a(a1), .b(b1), .borrow_in(bi1),
      .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: {borrow, diff} = a - b - bin taken modulo 2^(w+1)
   function automatic int ref_sub(input int w, input int av, input int bv, input int bin);
      int r;
      r = av - bv - bin;
      return r & ((1 << (w + 1)) - 1);
   endfunction

   // One WIDTH=8 operation; inj>0 pulses a stray start that many cycles into it
   task automatic op8(input int av, input int bv, input int bin, input int inj, input string tag);
      int         lat;
      int         r;
      int         ndone;
      logic [8:0] held;
      r = ref_sub(8, av, bv, bin);
      @(posedge clk); #1;
      a8 = 8'(av); b8 = 8'(bv); bi8 = 1'(bin); st8 = 1'b1;
      @(posedge clk); #1;
      st8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
      held = {bo8, diff8};
      chk({tag, "_busy"}, 32'(busy8), 32'd1);
      lat = 0;
      for (int c = 1; c <= 20 && lat == 0; c++) begin
         if (c == inj) begin
            st8 = 1'b1; a8 = 8'hAA; b8 = 8'h00;
         end
         @(posedge clk); #1;
         st8 = 1'b0;
         if (done8) lat = c;
         else if (held !== {bo8, diff8}) chk({tag, "_hold"}, 32'({bo8, diff8}), 32'(held));
      end
      chk({tag, "_lat"}, 32'(lat + 1), 32'd9);
      chk({tag, "_diff"}, 32'(diff8), 32'(r & 8'hFF));
      chk({tag, "_bo"}, 32'(bo8), 32'((r >> 8) & 1));
      chk({tag, "_busy_done"}, 32'(busy8), 32'd0);
      ndone = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done8) ndone++;
      end
      chk({tag, "_one_done"}, 32'(ndone), 32'd0);
   endtask

   // One operation on the WIDTH=4 or WIDTH=1 instance
   task automatic op_small(input int w, input int av, input int bv, input int bin);
      int          lat;
      int          r;
      logic        dn;
      logic [31:0] dv;
      logic [31:0] bov;
      r = ref_sub(w, av, bv, bin);
      @(posedge clk); #1;
      if (w == 4) begin
         st4 = 1'b1; a4 = 4'(av); b4 = 4'(bv); bi4 = 1'(bin);
      end else begin
         st1 = 1'b1; a1 = 1'(av); b1 = 1'(bv); bi1 = 1'(bin);
      end
      @(posedge clk); #1;
      st4 = 1'b0; st1 = 1'b0;
      lat = 0;
      for (int c = 1; c <= w + 4 && lat == 0; c++) begin
         @(posedge clk); #1;
         dn = (w == 4) ? done4 : done1;
         if (dn) lat = c;
      end
      dv  = (w == 4) ? 32'(diff4) : 32'(diff1);
      bov = (w == 4) ? 32'(bo4) : 32'(bo1);
      chk("small_lat", 32'(lat + 1), 32'(w + 1));
      chk("small_diff", dv, 32'(r & ((1 << w) - 1)));
      chk("small_bo", bov, 32'((r >> w) & 1));
   endtask

   // start held high: results every 9 cycles, outputs frozen between dones
   task automatic b2b();
      int         q[$];
      int         ndone;
      int         since;
      int         r;
      logic [8:0] last;
      @(posedge clk); #1;
      a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom); st8 = 1'b1;
      q.push_back(ref_sub(8, int'(a8), int'(b8), int'(bi8)));
      @(posedge clk); #1;
      last = {bo8, diff8};
      a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
      since = 0;
      ndone = 0;
      for (int c = 0; c < 80 && ndone < 5; c++) begin
         @(posedge clk); #1;
         since++;
         if (done8) begin
            ndone++;
            chk("b2b_period", 32'(since), (ndone == 1) ? 32'd8 : 32'd9);
            r = (q.size() > 0) ? q.pop_front() : -1;
            chk("b2b_result", 32'({bo8, diff8}), 32'(r & 9'h1FF));
            last  = {bo8, diff8};
            since = 0;
            if (ndone < 5) q.push_back(ref_sub(8, int'(a8), int'(b8), int'(bi8)));
            else st8 = 1'b0;
         end else begin
            if (last !== {bo8, diff8}) chk("b2b_hold", 32'({bo8, diff8}), 32'(last));
            a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
         end
      end
      chk("b2b_count", 32'(ndone), 32'd5);
      repeat (3) @(posedge clk);
      #1;
      chk("b2b_idle", 32'(busy8), 32'd0);
   endtask

   // Abort an op with reset four cycles in, then run a fresh op
   task automatic reset_abort();
      int ndone;
      @(posedge clk); #1;
      a8 = 8'h37; b8 = 8'h12; bi8 = 1'b0; st8 = 1'b1;
      @(posedge clk); #1;
      st8 = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("rst_busy", 32'(busy8), 32'd0);
      chk("rst_done", 32'(done8), 32'd0);
      chk("rst_diff", 32'(diff8), 32'd0);
      chk("rst_bo", 32'(bo8), 32'd0);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      ndone = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done8) ndone++;
      end
      chk("rst_no_done", 32'(ndone), 32'd0);
      op8(8'h80, 8'h01, 1, 0, "post_rst");
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      clk = 1'b0;
      rst_n = 1'b0;
      st8 = 1'b0; a8 = '0; b8 = '0; bi8 = 1'b0;
      st4 = 1'b0; a4 = '0; b4 = '0; bi4 = 1'b0;
      st1 = 1'b0; a1 = '0; b1 = '0; bi1 = 1'b0;
      #12;
      chk("reset_busy8", 32'(busy8), 32'd0);
      chk("reset_done8", 32'(done8), 32'd0);
      chk("reset_diff8", 32'(diff8), 32'd0);
      chk("reset_bo8", 32'(bo8), 32'd0);
      chk("reset_out4", 32'({busy4, done4, bo4, diff4}), 32'd0);
      chk("reset_out1", 32'({busy1, done1, bo1, diff1}), 32'd0);
      rst_n = 1'b1;

      op8(8'h05, 8'h03, 0, 0, "t5m3");
      op8(8'h03, 8'h05, 0, 0, "t3m5");
      op8(8'h00, 8'h00, 1, 0, "t0m0b");
      op8(8'hFF, 8'hFF, 1, 0, "tffb");
      op8(8'h00, 8'hFF, 0, 0, "t0mff");
      repeat (6) op8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 1)), 0, "rand");
      op8(8'h5A, 8'h21, 0, 3, "ignore_start");
      reset_abort();
      b2b();

      for (int av = 0; av < 16; av++)
         for (int bv = 0; bv < 16; bv++)
            for (int bin = 0; bin < 2; bin++)
               op_small(4, av, bv, bin);
      for (int av = 0; av < 2; av++)
         for (int bv = 0; bv < 2; bv++)
            for (int bin = 0; bin < 2; bin++)
               op_small(1, av, bv, bin);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
